// File: rtl/axi_txn_mon_if.sv
// AXI4-lite handshake and response signals observed by axi_txn_mon.
// The mon modport is input-only: the monitor never drives the bus.
interface axi_txn_mon_if;
    logic       awvalid;
    logic       awready;
    logic       wvalid;
    logic       wready;
    logic       bvalid;
    logic       bready;
    logic [1:0] bresp;
    logic       arvalid;
    logic       arready;
    logic       rvalid;
    logic       rready;
    logic [1:0] rresp;

    modport master (
        output awvalid, wvalid, bready, arvalid, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rresp
    );

    modport slave (
        input  awvalid, wvalid, bready, arvalid, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rresp
    );

    modport mon (
        input awvalid, awready, wvalid, wready, bvalid, bready, bresp,
              arvalid, arready, rvalid, rready, rresp
    );
endinterface

// File: rtl/axi_txn_mon.sv
// Passive AXI4-lite transaction monitor: outstanding counters, completion
// pulses for the RD/WR status counters, and sticky protocol error flags.
module axi_txn_mon #(
    parameter int unsigned CNT_W = 3,
    parameter int unsigned TO_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    axi_txn_mon_if.mon       bus,
    input  logic             err_clr,
    output logic             axi_wr_sync,
    output logic             axi_rd_sync,
    output logic [CNT_W-1:0] aw_pend,
    output logic [CNT_W-1:0] w_pend,
    output logic [CNT_W-1:0] rd_pend,
    output logic [4:0]       err_flags
);

    logic             hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic             b_legal, r_legal, busy;
    logic [CNT_W:0]   aw_nx, w_nx, rd_nx;
    logic [TO_W-1:0]  wd, wd_nx;
    logic             wd_fire;
    logic [4:0]       new_err, err_nx;

    // Returns {overflow, next_count}; decrement at zero holds, increment at max saturates.
    function automatic logic [CNT_W:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
        cnt_next = {1'b0, c};
        if (inc && !dec) begin
            if (c == '1) cnt_next = {1'b1, c};
            else         cnt_next = {1'b0, c + 1'b1};
        end else if (dec && !inc && c != '0) begin
            cnt_next = {1'b0, c - 1'b1};
        end
    endfunction

    always_comb begin
        hs_aw   = bus.awvalid & bus.awready;
        hs_w    = bus.wvalid  & bus.wready;
        hs_b    = bus.bvalid  & bus.bready;
        hs_ar   = bus.arvalid & bus.arready;
        hs_r    = bus.rvalid  & bus.rready;

        b_legal = (aw_pend != '0 || hs_aw) && (w_pend != '0 || hs_w);
        r_legal = (rd_pend != '0 || hs_ar);

        aw_nx   = cnt_next(aw_pend, hs_aw, hs_b);
        w_nx    = cnt_next(w_pend,  hs_w,  hs_b);
        rd_nx   = cnt_next(rd_pend, hs_ar, hs_r);

        busy    = (aw_pend != '0) || (w_pend != '0) || (rd_pend != '0);
        wd_nx   = wd;
        wd_fire = 1'b0;
        if (hs_b || hs_r || !busy) begin
            wd_nx = '0;
        end else if (wd != '1) begin
            wd_nx   = wd + 1'b1;
            wd_fire = (wd_nx == '1);
        end

        new_err[0] = hs_b & ~b_legal;
        new_err[1] = hs_r & ~r_legal;
        new_err[2] = aw_nx[CNT_W] | w_nx[CNT_W] | rd_nx[CNT_W];
        new_err[3] = (hs_b & bus.bresp[1]) | (hs_r & bus.rresp[1]);
        new_err[4] = wd_fire;

        // A clear and a fresh error in the same cycle leave the fresh bit set.
        err_nx = (err_clr ? 5'b0 : err_flags) | new_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_pend     <= '0;
            w_pend      <= '0;
            rd_pend     <= '0;
            wd          <= '0;
            err_flags   <= '0;
            axi_wr_sync <= 1'b0;
            axi_rd_sync <= 1'b0;
        end else begin
            aw_pend     <= aw_nx[CNT_W-1:0];
            w_pend      <= w_nx[CNT_W-1:0];
            rd_pend     <= rd_nx[CNT_W-1:0];
            wd          <= wd_nx;
            err_flags   <= err_nx;
            axi_wr_sync <= hs_b;
            axi_rd_sync <= hs_r;
        end
    end

endmodule

// File: tb/tb_axi_txn_mon.sv
// Scoreboard bench for axi_txn_mon: directed scenarios then random traffic,
// checked every cycle against an integer reference model.
module tb_axi_txn_mon;

    localparam int MAXC  = 7;
    localparam int TOMAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr;
    logic       axi_wr_sync, axi_rd_sync;
    logic [2:0] aw_pend, w_pend, rd_pend;
    logic [4:0] err_flags;

    always #5 clk = ~clk;

    axi_txn_mon_if bus ();

    axi_txn_mon #(.CNT_W(3), .TO_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_clr     (err_clr),
        .axi_wr_sync (axi_wr_sync),
        .axi_rd_sync (axi_rd_sync),
        .aw_pend     (aw_pend),
        .w_pend      (w_pend),
        .rd_pend     (rd_pend),
        .err_flags   (err_flags)
    );

    typedef struct {
        int       wr;
        int       rd;
        int       aw;
        int       w;
        int       rdp;
        bit [4:0] err;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    int       m_aw = 0, m_w = 0, m_rd = 0, m_wd = 0;
    bit [4:0] m_err = '0;

    function automatic int clampc(input int v, inout bit ovf);
        if (v > MAXC) begin
            ovf = 1'b1;
            return MAXC;
        end
        if (v < 0) return 0;
        return v;
    endfunction

    initial begin : model
        int       haw, hw, hb, har, hr;
        bit       busy, ovf;
        bit [4:0] ne;
        exp_t     e;
        forever begin
            @(posedge clk);
            haw = int'(bus.awvalid && bus.awready);
            hw  = int'(bus.wvalid  && bus.wready);
            hb  = int'(bus.bvalid  && bus.bready);
            har = int'(bus.arvalid && bus.arready);
            hr  = int'(bus.rvalid  && bus.rready);
            if (rst) begin
                m_aw = 0; m_w = 0; m_rd = 0; m_wd = 0; m_err = '0;
                e.wr = 0; e.rd = 0;
            end else begin
                busy = (m_aw + m_w + m_rd) > 0;
                ne   = '0;
                if (hb != 0 && !((m_aw > 0 || haw != 0) && (m_w > 0 || hw != 0))) ne[0] = 1'b1;
                if (hr != 0 && !(m_rd > 0 || har != 0)) ne[1] = 1'b1;
                if ((hb != 0 && bus.bresp[1]) || (hr != 0 && bus.rresp[1])) ne[3] = 1'b1;
                ovf  = 1'b0;
                m_aw = clampc(m_aw + haw - hb, ovf);
                m_w  = clampc(m_w  + hw  - hb, ovf);
                m_rd = clampc(m_rd + har - hr, ovf);
                ne[2] = ovf;
                if (hb != 0 || hr != 0 || !busy) m_wd = 0;
                else if (m_wd < TOMAX) begin
                    m_wd++;
                    if (m_wd == TOMAX) ne[4] = 1'b1;
                end
                m_err = (err_clr ? 5'b0 : m_err) | ne;
                e.wr = hb; e.rd = hr;
            end
            e.aw = m_aw; e.w = m_w; e.rdp = m_rd; e.err = m_err;
            q.push_back(e);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: no expected entry at %0t", $time);
            end else begin
                e = q.pop_front();
                check("axi_wr_sync", int'(axi_wr_sync), e.wr);
                check("axi_rd_sync", int'(axi_rd_sync), e.rd);
                check("aw_pend",     int'(aw_pend),     e.aw);
                check("w_pend",      int'(w_pend),      e.w);
                check("rd_pend",     int'(rd_pend),     e.rdp);
                check("err_flags",   int'(err_flags),   int'(e.err));
            end
        end
    end

    task automatic step(input bit aw, input bit w, input bit b, input bit ar, input bit r,
                        input logic [1:0] br, input logic [1:0] rr, input bit clr);
        bus.awvalid = aw; bus.awready = aw;
        bus.wvalid  = w;  bus.wready  = w;
        bus.bvalid  = b;  bus.bready  = b;  bus.bresp = br;
        bus.arvalid = ar; bus.arready = ar;
        bus.rvalid  = r;  bus.rready  = r;  bus.rresp = rr;
        err_clr     = clr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    endtask

    initial begin : stim
        err_clr = 1'b0;
        bus.awvalid = 0; bus.awready = 0; bus.wvalid = 0; bus.wready = 0;
        bus.bvalid = 0; bus.bready = 0; bus.bresp = 0;
        bus.arvalid = 0; bus.arready = 0; bus.rvalid = 0; bus.rready = 0; bus.rresp = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic write: AW, W, B
        step(1, 0, 0, 0, 0, 2'b00, 2'b00, 0); idle(1);
        step(0, 1, 0, 0, 0, 2'b00, 2'b00, 0); idle(1);
        step(0, 0, 1, 0, 0, 2'b00, 2'b00, 0); idle(2);

        // W first, then AW and B together
        step(0, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        step(1, 0, 1, 0, 0, 2'b01, 2'b00, 0); idle(2);

        // Read overflow then drain with one extra R
        repeat (8) step(0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
        repeat (8) step(0, 0, 0, 0, 1, 2'b00, 2'b01, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 2'b00, 2'b00, 1); idle(1);

        // Error responses on B and R in the same cycle, then clear
        step(0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
        step(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        step(0, 0, 1, 0, 1, 2'b11, 2'b10, 0); idle(1);
        step(0, 0, 0, 0, 0, 2'b00, 2'b00, 1); idle(1);

        // Watchdog timeout
        step(0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
        idle(260);
        step(0, 0, 0, 0, 1, 2'b00, 2'b00, 0); idle(2);
        step(0, 0, 0, 0, 0, 2'b00, 2'b00, 1);

        // Reset mid-transaction, then an orphan B
        repeat (3) step(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        rst = 1'b1; idle(1); rst = 1'b0;
        step(0, 0, 1, 0, 0, 2'b00, 2'b00, 0); idle(1);
        // Clear coinciding with a new error keeps the new bit
        step(0, 0, 1, 0, 0, 2'b00, 2'b00, 1); idle(1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.awvalid = ($urandom_range(0, 99) < 40);
            bus.awready = ($urandom_range(0, 99) < 60);
            bus.wvalid  = ($urandom_range(0, 99) < 40);
            bus.wready  = ($urandom_range(0, 99) < 60);
            bus.bvalid  = ($urandom_range(0, 99) < 30);
            bus.bready  = ($urandom_range(0, 99) < 60);
            bus.bresp   = 2'($urandom_range(0, 3));
            bus.arvalid = ($urandom_range(0, 99) < 40);
            bus.arready = ($urandom_range(0, 99) < 60);
            bus.rvalid  = ($urandom_range(0, 99) < 30);
            bus.rready  = ($urandom_range(0, 99) < 60);
            bus.rresp   = 2'($urandom_range(0, 3));
            err_clr     = ($urandom_range(0, 29) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
